// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with transmit FIFO, runtime parity (none/even/odd) and 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the send_break input and break generation (BRK state).
module uart_tx_fifo_cfg #(
   parameter int DATA_W     = 8,
   parameter int BAUD_W     = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          trmt,
   input  logic [DATA_W-1:0]             tx_data,
   input  logic [BAUD_W-1:0]             baud,
   input  logic                          parity_en,
   input  logic                          parity_odd,
   input  logic                          two_stop,
`ifdef UART_TX_BREAK_EN
   input  logic                          send_break,
`endif
   output logic                          TX,
   output logic                          tx_done,
   output logic                          busy,
   output logic                          fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
   output logic                          overflow
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0]     LAST_BIT = CW'(DATA_W - 1);
   localparam logic [AW:0]       FULL_CNT = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW-1:0]     PTR_ONE  = AW'(1);
   localparam logic [AW:0]       CNT_ONE  = (AW + 1)'(1);
   localparam logic [CW-1:0]     BIT_ONE  = CW'(1);
   localparam logic [BAUD_W-1:0] DIV_ONE  = BAUD_W'(1);
   localparam logic [BAUD_W-1:0] DIV_TWO  = BAUD_W'(2);

   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
`ifdef UART_TX_BREAK_EN
      , BRK, BRK_END
`endif
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0]       r_wptr, r_rptr;
   logic [AW:0]         r_cnt;
   logic                r_overflow;
   logic [DATA_W-1:0]   r_shift;
   logic [CW-1:0]       r_bitcnt;
   logic [BAUD_W-1:0]   r_div, r_bt;
   logic                r_par_en, r_par_bit, r_two_stop, r_stop2;
   logic                r_tx, r_busy, r_done;
   logic                w_pop, w_push, w_tick, w_fifo_ne, w_full, w_brk_req;
   logic [BAUD_W-1:0]   w_bt;

`ifdef UART_TX_BREAK_EN
   assign w_brk_req = send_break;
`else
   assign w_brk_req = 1'b0;
`endif

   assign w_bt      = (baud < DIV_TWO) ? DIV_TWO : baud;
   assign w_tick    = (r_div == '0);
   assign w_fifo_ne = (r_cnt != '0);
   assign w_full    = (r_cnt == FULL_CNT);
   // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted.
   assign w_push    = trmt && (!w_full || w_pop);

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         IDLE: begin
`ifdef UART_TX_BREAK_EN
            if (send_break) w_state_nxt = BRK;
            else
`endif
            if (w_fifo_ne) begin
               w_state_nxt = START;
               w_pop       = 1'b1;
            end
         end
         START:  if (w_tick) w_state_nxt = DATA;
         DATA:   if (w_tick && r_bitcnt == LAST_BIT) w_state_nxt = r_par_en ? PARITY : STOP;
         PARITY: if (w_tick) w_state_nxt = STOP;
         STOP: begin
            if (w_tick && (!r_two_stop || r_stop2)) begin
               if (w_fifo_ne && !w_brk_req) begin
                  w_state_nxt = START;
                  w_pop       = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
`ifdef UART_TX_BREAK_EN
         BRK:     if (!send_break) w_state_nxt = BRK_END;
         BRK_END: if (w_tick) w_state_nxt = IDLE;
`endif
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= tx_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_cnt      <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PTR_ONE;
         if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CNT_ONE;
            2'b01:   r_cnt <= r_cnt - CNT_ONE;
            default: r_cnt <= r_cnt;
         endcase
         if (trmt && !w_push) r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bitcnt   <= '0;
         r_div      <= '0;
         r_bt       <= DIV_TWO;
         r_par_en   <= 1'b0;
         r_par_bit  <= 1'b0;
         r_two_stop <= 1'b0;
         r_stop2    <= 1'b0;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_pop) begin
            // Frame start: configuration is frozen here for the whole frame.
            r_shift    <= r_mem[r_rptr];
            r_par_bit  <= (^r_mem[r_rptr]) ^ parity_odd;
            r_par_en   <= parity_en;
            r_two_stop <= two_stop;
            r_bt       <= w_bt;
            r_div      <= w_bt - DIV_ONE;
            r_bitcnt   <= '0;
            r_stop2    <= 1'b0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
         end else begin
            if (r_state != IDLE) r_div <= w_tick ? (r_bt - DIV_ONE) : (r_div - DIV_ONE);
            case (r_state)
               IDLE: begin
`ifdef UART_TX_BREAK_EN
                  if (w_state_nxt == BRK) begin
                     r_tx <= 1'b0;
                     r_bt <= w_bt;
                  end
`endif
               end
               START: if (w_tick) r_tx <= r_shift[0];
               DATA: begin
                  if (w_tick) begin
                     if (r_bitcnt == LAST_BIT) begin
                        r_tx <= r_par_en ? r_par_bit : 1'b1;
                     end else begin
                        r_shift  <= r_shift >> 1;
                        r_tx     <= r_shift[1];
                        r_bitcnt <= r_bitcnt + BIT_ONE;
                     end
                  end
               end
               PARITY: if (w_tick) r_tx <= 1'b1;
               STOP: begin
                  if (w_tick) begin
                     if (r_two_stop && !r_stop2) begin
                        r_stop2 <= 1'b1;
                     end else begin
                        r_tx   <= 1'b1;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                     end
                  end
               end
`ifdef UART_TX_BREAK_EN
               BRK: begin
                  if (!send_break) begin
                     r_tx  <= 1'b1;
                     r_div <= r_bt - DIV_ONE;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign TX        = r_tx;
   assign tx_done   = r_done;
   assign busy      = r_busy;
   assign fifo_full = w_full;
   assign fifo_cnt  = r_cnt;
   assign overflow  = r_overflow;
endmodule

// File: doc/uart_tx_fifo_cfg.md
Name: uart_tx_fifo_cfg

Overview:
Parametrised UART transmitter and next generation of the team's configurable-baud transmitter. It adds a configurable data width, an internal transmit FIFO, runtime parity (none/even/odd) and runtime 1 or 2 stop bits. The block sits between the command/response logic and the serial TX pin, and lets the producer queue several bytes back-to-back without waiting for each frame to finish.

Parameters:
DATA_W, 8, data bits per frame (5..9)
BAUD_W, 16, width of baud divisor input
FIFO_DEPTH, 4, transmit FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
trmt  in  1  push tx_data into FIFO this cycle
tx_data  in  DATA_W  data word to queue
baud  in  BAUD_W  clocks per bit; values 0 and 1 are treated as 2
parity_en  in  1  append parity bit
parity_odd  in  1  1 = odd parity, 0 = even parity
two_stop  in  1  1 = two stop bits, 0 = one stop bit
TX  out  1  serial output, idles high
tx_done  out  1  set at end of a frame, cleared when the next frame starts
busy  out  1  frame in progress
fifo_full  out  1  FIFO holds FIFO_DEPTH entries
fifo_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
overflow  out  1  sticky; set when trmt arrives while full

Behaviour:
- Reset (asynchronous, rst=1): FIFO empty, fifo_cnt=0, TX=1, tx_done=0, busy=0, fifo_full=0, overflow=0, FSM=IDLE.
- Push: trmt=1 with fifo_full=0 writes tx_data on that edge.
- trmt=1 with fifo_full=1: data is dropped and overflow is set. Only reset clears overflow.
- Simultaneous push and pop while full: the pop frees a slot, so the push is accepted and overflow is not set.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START when the FIFO is non-empty. On that edge:
  - pop the FIFO head into the shift register;
  - latch the baud divisor, parity_en, parity_odd and two_stop;
  - set busy=1, clear tx_done, drive TX=0.
  - Mid-frame config changes are ignored.
- Latency: trmt high in cycle c with the FIFO empty and IDLE -> TX low from cycle c+2.
- Each bit lasts exactly B clocks, where B = max(baud,2) as latched. A down-counter reloads B-1 at bit start and advances the bit at 0.
- Bit order per frame:
  - start bit = 0;
  - DATA_W data bits, LSB first;
  - if parity is enabled, a parity bit = XOR of the data bits, inverted when parity_odd=1;
  - 1 or 2 stop bits = 1.
- Frame length = (1 + DATA_W + parity_en + 1 + two_stop) * B clocks.
- At the end of the last stop bit:
  - if the FIFO is non-empty, go directly to START on the same edge. There is no idle gap between frames. tx_done pulses 0 (it is set and cleared on the same edge, so the clear wins and it stays 0) and busy stays 1.
  - otherwise go to IDLE, set tx_done=1, busy=0, TX=1.
- The data bit counter width is $clog2(DATA_W+1).
- The divisor counter is BAUD_W bits and never underflows.
- TX is registered (flop output) and glitch-free.
- Reset mid-frame: TX returns to 1 immediately and the FIFO contents are discarded.

Optional Feature:
Macro UART_TX_BREAK_EN.
- Defined: adds input port send_break (1 bit).
  - send_break=1 while IDLE: enter state BRK and hold TX=0 while send_break stays high. On deassertion, hold TX=1 for one bit time B, then return to IDLE. tx_done is not touched.
  - send_break=1 while busy: ignored until the current frame ends. Break takes priority over FIFO data at that IDLE decision.
- Not defined: no send_break port, no BRK state, behaviour exactly as above.

Test Plan:
1. Reset, then push 0xA5 with baud=4, no parity, 1 stop -> TX low from cycle c+2. Sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks, 40 clocks total. tx_done=1 after, busy=0.
2. parity_en=1, parity_odd=0, push 0x07 (three ones) -> parity bit 1. Repeat with parity_odd=1 -> parity bit 0. Frame = 11 bits.
3. two_stop=1, baud=3, push 0x00 -> TX high for 6 clocks at the end. Change two_stop to 0 mid-frame -> still 2 stop bits.
4. Push 5 words back-to-back with FIFO_DEPTH=4 while the first frame transmits -> all 5 sent with no idle gap and overflow stays 0. Then push 6 words in 6 consecutive cycles while IDLE -> overflow=1 and the 6th word never appears.
5. baud=0 -> bit time 2 clocks. baud=1 -> bit time 2 clocks.
6. Assert rst mid-DATA -> TX=1, busy=0, fifo_cnt=0, tx_done=0 immediately. After release, a new push transmits correctly.
